// File: rtl/dct_pkg.sv
// Shared definitions for the distributed-arithmetic 8-point DCT.
// Holds the coefficient table, widths, FSM states and a mask helper.
package dct_pkg;

  localparam int COEF_W = 16;
  localparam int ROM_W  = 18;
  localparam int N      = 8;

  typedef enum logic [1:0] {IDLE, BFLY, ACC, OUT} state_t;

  // round(0.5*c_k*cos((2j+1)k*pi/16)*2^14); only j=0..3 is needed after the butterfly
  localparam logic signed [COEF_W-1:0] DCT_C [8][4] = '{
    '{ 16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793},
    '{ 16'sd8035,  16'sd6811,  16'sd4551,  16'sd1598},
    '{ 16'sd7568,  16'sd3135, -16'sd3135, -16'sd7568},
    '{ 16'sd6811, -16'sd1598, -16'sd8035, -16'sd4551},
    '{ 16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793},
    '{ 16'sd4551, -16'sd8035,  16'sd1598,  16'sd6811},
    '{ 16'sd3135, -16'sd7568,  16'sd7568, -16'sd3135},
    '{ 16'sd1598, -16'sd4551,  16'sd6811, -16'sd8035}
  };

  function automatic logic [2:0] lowest_set(input logic [N-1:0] m);
    lowest_set = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/dct_da_rom.sv
// Combinational DA lookup: ROM[k][a] = sum of DCT_C[k][j] over set bits j of a.
// Zero latency; no flow control.
module dct_da_rom
  import dct_pkg::*;
(
  input  logic [2:0]              k,
  input  logic [3:0]              a,
  output logic signed [ROM_W-1:0] rom_dat
);

  logic signed [COEF_W-1:0] c;

  always_comb begin
    rom_dat = '0;
    c       = '0;
    for (int j = 0; j < 4; j++) begin
      c = DCT_C[k][j];
      if (a[j]) rom_dat = rom_dat + {{(ROM_W - COEF_W){c[COEF_W-1]}}, c};
    end
  end

endmodule

// File: rtl/dct8_da_engine.sv
// Bit-serial DA 8-point DCT: one block per handshake, one coefficient Zk per beat for each mask bit.
// First beat IN_W+3 cycles after accept, IN_W+2 per further beat; out beat held while !out_ready.
module dct8_da_engine
  import dct_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 19,
  parameter int SHIFT = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*IN_W-1:0] in_data,
  input  logic [N-1:0]      in_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [2:0]        out_idx,
  output logic              out_last,
  output logic              busy
);

  localparam int VW    = IN_W + 1;
  localparam int ACC_W = IN_W + 19;
  localparam int BW    = $clog2(IN_W + 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef struct packed {
    logic [3:0][VW-1:0] s;
    logic [3:0][VW-1:0] d;
  } bfly_t;

  state_t                  state_q, state_d;
  logic [N*IN_W-1:0]       x_q, x_d;
  logic [N-1:0]            mask_q, mask_d;
  bfly_t                   bf_q, bf_d;
  logic [2:0]              k_q, k_d;
  logic [BW-1:0]           b_q, b_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic [2:0]              out_idx_q, out_idx_d;
  logic                    out_last_q, out_last_d;

  bfly_t                   bf_calc;
  logic [IN_W-1:0]         x_lo, x_hi;
  logic [3:0][VW-1:0]      v;
  logic [3:0]              rom_a;
  logic signed [ROM_W-1:0] rom_dat;
  logic signed [ACC_W-1:0] rom_ext, acc_step, acc_shr;
  logic [OUT_W-1:0]        sat_dat;
  logic [2:0]              k_next;
  logic [N-1:0]            mask_clr;

  dct_da_rom u_rom (
    .k       (k_q),
    .a       (rom_a),
    .rom_dat (rom_dat)
  );

  always_comb begin
    bf_calc = '0;
    x_lo    = '0;
    x_hi    = '0;
    for (int n = 0; n < 4; n++) begin
      x_lo = x_q[n*IN_W +: IN_W];
      x_hi = x_q[(N-1-n)*IN_W +: IN_W];
      bf_calc.s[n] = {x_lo[IN_W-1], x_lo} + {x_hi[IN_W-1], x_hi};
      bf_calc.d[n] = {x_lo[IN_W-1], x_lo} - {x_hi[IN_W-1], x_hi};
    end
  end

  // Even coefficients use the sums, odd ones the differences; b walks from the sign plane down.
  always_comb begin
    v     = k_q[0] ? bf_q.d : bf_q.s;
    rom_a = '0;
    for (int j = 0; j < 4; j++) rom_a[j] = v[j][b_q];
    rom_ext  = {{(ACC_W - ROM_W){rom_dat[ROM_W-1]}}, rom_dat};
    acc_step = (b_q == BW'(IN_W)) ? (acc_q <<< 1) - rom_ext : (acc_q <<< 1) + rom_ext;
    acc_shr  = acc_step >>> SHIFT;
    if (acc_shr > SAT_MAX)      sat_dat = SAT_MAX[OUT_W-1:0];
    else if (acc_shr < SAT_MIN) sat_dat = SAT_MIN[OUT_W-1:0];
    else                        sat_dat = acc_shr[OUT_W-1:0];
  end

  assign k_next   = lowest_set(mask_q);
  assign mask_clr = mask_q & ~(N'(1) << k_next);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    mask_d      = mask_q;
    bf_d        = bf_q;
    k_d         = k_q;
    b_d         = b_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d    = in_data;
          mask_d = in_mask;
          if (in_mask != '0) state_d = BFLY;
        end
      end
      BFLY: begin
        bf_d    = bf_calc;
        k_d     = k_next;
        mask_d  = mask_clr;
        acc_d   = '0;
        b_d     = BW'(IN_W);
        state_d = ACC;
      end
      ACC: begin
        acc_d = acc_step;
        if (b_q == '0) begin
          out_valid_d = 1'b1;
          out_data_d  = sat_dat;
          out_idx_d   = k_q;
          out_last_d  = (mask_q == '0);
          state_d     = OUT;
        end else begin
          b_d = b_q - BW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (mask_q != '0) begin
            k_d     = k_next;
            mask_d  = mask_clr;
            acc_d   = '0;
            b_d     = BW'(IN_W);
            state_d = ACC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      mask_q      <= '0;
      bf_q        <= '0;
      k_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      mask_q      <= mask_d;
      bf_q        <= bf_d;
      k_q         <= k_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_dct8_da_engine.sv
// Bench for dct8_da_engine: fixed vectors, handshake corner sequences and random blocks
// against a direct 8-tap DCT model; a second OUT_W=8 instance covers saturation.
module tb_dct8_da_engine;

  localparam real PI = 3.14159265358979323846;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [63:0] in_data;
  logic [7:0]  in_mask;
  logic        out_valid, out_ready;
  logic [18:0] out_data;
  logic [2:0]  out_idx;
  logic        out_last, busy;

  logic        in_valid8, in_ready8;
  logic [63:0] in_data8;
  logic [7:0]  in_mask8;
  logic        out_valid8, out_ready8;
  logic [7:0]  out_data8;
  logic [2:0]  out_idx8;
  logic        out_last8, busy8;

  int n_cmp = 0;
  int n_bad = 0;
  int coef_full [8][8];

  dct8_da_engine #(.IN_W(8), .OUT_W(19), .SHIFT(14)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  dct8_da_engine #(.IN_W(8), .OUT_W(8), .SHIFT(14)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_mask(in_mask8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_idx(out_idx8), .out_last(out_last8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Direct definition of the DCT: Z_k = floor(sum_n x_n*C_k,n / 2^14), then clamp to ow bits.
  function automatic longint ref_z(input logic [63:0] x, input int k, input int ow);
    longint sum, q, mx, mn;
    sum = 0;
    for (int n = 0; n < 8; n++) begin
      logic [7:0] xb;
      xb  = x[n*8 +: 8];
      sum = sum + longint'($signed(xb)) * longint'(coef_full[k][n]);
    end
    q  = sum >>> 14;
    mx = (longint'(1) <<< (ow - 1)) - 1;
    mn = -mx - 1;
    if (q > mx) q = mx;
    if (q < mn) q = mn;
    return q;
  endfunction

  task automatic send(input logic [63:0] x, input logic [7:0] m);
    int t;
    t = 0;
    in_data  = x;
    in_mask  = m;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("send_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic recv_block(input string tag, input logic [7:0] m, input int ez [8], input int stall_at);
    int beat;
    int extra;
    beat = 0;
    for (int k = 0; k < 8; k++) begin
      if (m[k]) begin
        int t;
        int unstable;
        logic [18:0] hd;
        logic [2:0]  hi;
        logic        hl;
        if (beat == stall_at) out_ready = 1'b0;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 60) begin
          @(negedge clk);
          t++;
        end
        check({tag, "_valid"}, out_valid, 1);
        if (beat == stall_at) begin
          hd = out_data;
          hi = out_idx;
          hl = out_last;
          unstable = 0;
          repeat (20) begin
            @(negedge clk);
            if (!out_valid || out_data !== hd || out_idx !== hi || out_last !== hl) unstable++;
          end
          check({tag, "_stall_stable"}, unstable, 0);
          @(posedge clk);
          #1 out_ready = 1'b1;
          @(negedge clk);
        end
        check({tag, "_data"}, longint'($signed(out_data)), ez[k]);
        check({tag, "_idx"}, out_idx, k);
        check({tag, "_last"}, out_last, ((m >> (k + 1)) == 8'h00) ? 1 : 0);
        @(posedge clk);
        #1;
        beat++;
      end
    end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check({tag, "_no_extra_beat"}, extra, 0);
    check({tag, "_idle"}, busy, 0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [63:0] x;
    logic [7:0]  m;
    int          z [8];
  } vec_t;

  initial begin
    vec_t        vt [4];
    int          ez [8];
    int          zero8 [8];
    logic [63:0] x;
    logic [7:0]  m;
    int          lat, t, stall_at;
    real         ck, cv;

    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < 8; n++) begin
        ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        cv = 0.5 * ck * $cos(real'((2 * n + 1) * k) * PI / 16.0) * 16384.0;
        coef_full[k][n] = (cv >= 0.0) ? int'($floor(cv + 0.5)) : -int'($floor(-cv + 0.5));
      end
    end
    zero8 = '{0, 0, 0, 0, 0, 0, 0, 0};

    vt[0].x = {8{8'd10}};       vt[0].m = 8'hFF; vt[0].z = '{28, 0, 0, 0, 0, 0, 0, 0};
    vt[1].x = 64'd100;          vt[1].m = 8'h03; vt[1].z = '{35, 49, 0, 0, 0, 0, 0, 0};
    vt[2].x = {56'd0, 8'h9C};   vt[2].m = 8'h03; vt[2].z = '{-36, -50, 0, 0, 0, 0, 0, 0};
    vt[3].x = 64'd100;          vt[3].m = 8'h20; vt[3].z = '{0, 0, 0, 0, 0, 27, 0, 0};

    in_valid  = 1'b0; in_data  = '0; in_mask  = '0; out_ready  = 1'b1;
    in_valid8 = 1'b0; in_data8 = '0; in_mask8 = '0; out_ready8 = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      send(vt[i].x, vt[i].m);
      recv_block($sformatf("tbl%0d", i), vt[i].m, vt[i].z, (i == 0) ? 3 : -1);
    end

    // First-beat latency, measured from the handshake cycle, with the first beat stalled.
    out_ready = 1'b0;
    in_data   = vt[1].x;
    in_mask   = vt[1].m;
    in_valid  = 1'b1;
    @(negedge clk);
    check("lat_accept_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("first_beat_latency", lat, 11);
    @(posedge clk);
    #1;
    recv_block("lat_blk", vt[1].m, vt[1].z, 0);

    // Empty mask: block is swallowed in IDLE.
    send({8{8'd33}}, 8'h00);
    check("mask0_in_ready", in_ready, 1);
    recv_block("mask0", 8'h00, zero8, -1);

    // Reset while accumulating the second coefficient.
    send(64'd100, 8'h03);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("rstmid_first_z0", longint'($signed(out_data)), 35);
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #3;
    check("rstmid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_out_data", out_data, 0);
    check("rstmid_out_idx", out_idx, 0);
    check("rstmid_out_last", out_last, 0);
    check("rstmid_in_ready", in_ready, 1);
    check("rstmid_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(vt[2].x, vt[2].m);
    recv_block("after_rst", vt[2].m, vt[2].z, -1);

    for (int r = 0; r < 30; r++) begin
      x = {$urandom, $urandom};
      m = 8'($urandom_range(0, 255));
      for (int k = 0; k < 8; k++) ez[k] = int'(ref_z(x, k, 19));
      stall_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      send(x, m);
      recv_block($sformatf("rnd%0d", r), m, ez, stall_at);
    end

    // Narrow-output instance: saturation at both rails plus a few random single coefficients.
    for (int i = 0; i < 6; i++) begin
      int k8;
      longint e8;
      k8 = (i < 2) ? 0 : int'($urandom_range(0, 7));
      x  = (i == 0) ? {8{8'd127}} : (i == 1) ? {8{8'h80}} : {$urandom, $urandom};
      e8 = (i == 0) ? 127 : (i == 1) ? -128 : ref_z(x, k8, 8);
      in_data8  = x;
      in_mask8  = 8'(1 << k8);
      in_valid8 = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_ready8 && t < 60) begin
        @(negedge clk);
        t++;
      end
      @(posedge clk);
      #1 in_valid8 = 1'b0;
      t = 0;
      @(negedge clk);
      while (!out_valid8 && t < 60) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("sat%0d_valid", i), out_valid8, 1);
      check($sformatf("sat%0d_data", i), longint'($signed(out_data8)), e8);
      check($sformatf("sat%0d_idx", i), out_idx8, k8);
      check($sformatf("sat%0d_last", i), out_last8, 1);
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dct8_da_engine.md
Name: dct8_da_engine

Overview:
- Parametrised 8-point 1-D DCT engine using bit-serial distributed arithmetic (DA); successor to the single-coefficient DCT slices.
- Accepts one 8-sample block per valid/ready handshake and computes any subset of the coefficients Z0..Z7, selected by a per-block mask.
- Emits one coefficient per output beat, with index and last flag, into the downstream RLE/packing stage.

Parameters:
- IN_W, 8, signed sample width.
- OUT_W, 19, signed output coefficient width (saturated).
- SHIFT, 14, arithmetic right shift applied to the accumulator before saturation; 14 = coefficient fraction bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  block valid.
- in_ready  out  1  engine can accept a block.
- in_data  in  8*IN_W  samples x0..x7, x0 in the LSBs.
- in_mask  in  8  bit k set = compute Zk; captured with the block.
- out_valid  out  1  coefficient valid.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_W  signed coefficient Zk.
- out_idx  out  3  k of out_data.
- out_last  out  1  last selected coefficient of the block.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, all internal registers cleared. Reset mid-block aborts the block; no partial output.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_data and in_mask. If in_mask==0, stay in IDLE (block dropped, no output). Otherwise go to BFLY.
  - BFLY: one cycle. Register s_n = x_n + x_(7-n) and d_n = x_n - x_(7-n), n=0..3, each IN_W+1 bits signed. Select k = lowest set mask bit. Clear acc, set bit counter b = IN_W. Go to ACC.
  - ACC: IN_W+1 cycles. Take the operand vector v = s for even k, d for odd k. Address a = {v3[b], v2[b], v1[b], v0[b]}. Update acc <= (acc<<1) + R, where R = -ROM[k][a] if b == IN_W (sign plane), else +ROM[k][a]. Then b--. After the b=0 update:
    - out_data = sat_OUT_W(acc_final >>> SHIFT), floor semantics;
    - out_idx = k;
    - out_last = 1 if no higher mask bit remains;
    - out_valid = 1; go to OUT.
  - OUT: hold out_data, out_idx and out_last stable while out_valid && !out_ready.
    - On out_ready with more mask bits pending: drop out_valid, take the next higher set k, clear acc, set b = IN_W, go to ACC.
    - On out_ready with none pending: go to IDLE.
- Latency: first out_valid rises IN_W+3 cycles after the accepting edge (11 at IN_W=8). With out_ready held high, each further coefficient takes IN_W+2 cycles.
- ROM: ROM[k][a] = sum of C[k][j] over the set bits j of a.
  - C[k][j] = round(0.5·c_k·cos((2j+1)kπ/16)·2^14), with c_0 = 1/√2 and c_k = 1 otherwise, as 16-bit signed.
  - ROM entries are 18-bit signed. acc width is IN_W+19.
- Saturation: values above 2^(OUT_W-1)-1 clamp to the maximum; values below -2^(OUT_W-1) clamp to the minimum.
- in_ready is 0 in every state except IDLE; there is no overlap between blocks.

Decomposition:
- Package dct_pkg holds:
  - the 8x4 coefficient table C (16-bit);
  - localparams COEF_W=16, ROM_W=18, N=8;
  - the state enum {IDLE, BFLY, ACC, OUT}.
- Sub-module dct_da_rom: a combinational lookup, (k[2:0], a[3:0]) -> 18-bit ROM[k][a], built from the dct_pkg table.
- The engine instantiates one dct_da_rom and contains the FSM, butterfly, accumulator and saturation logic.

Test Plan:
- All samples 10, mask 0xFF: 8 beats. Z0 = 28 (80·5793 = 463440, >>>14); Z1..Z7 = 0; out_idx 0..7; out_last only on idx 7.
- Impulse x0=100, others 0, mask 0x03: Z0 = 35, Z1 = 49 (C10 = 8035). Then x0=-100: Z0 = -36, confirming floor on the arithmetic shift.
- Mask 0x00 with in_valid: in_ready stays 1, no out_valid. Mask 0x20: a single beat with out_idx=5 and out_last=1.
- Backpressure: hold out_ready=0 for 20 cycles mid-block. out_data, out_idx and out_last stay stable and no beat is lost or duplicated. The first out_valid comes 11 cycles after acceptance.
- OUT_W=8 build, all samples 127, mask 0x01: raw value 359 saturates to 127. All samples -128, mask 0x01: raw value -363 saturates to -128.
- Assert rst_n low during ACC: outputs go to reset values immediately. After release, a new block produces correct results.
